// File: rtl/gamma_page_scheduler_pkg.sv
// gamma_page_scheduler_pkg: shared video constants and scheduler state encoding
package gamma_page_scheduler_pkg;
    localparam logic [3:0] GAMMA_OFF = 4'd5;
    localparam logic [3:0] GAMMA_MAX = 4'd8;
    localparam int NVSYNC_BIT = 3;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HOLD = 2'd2
    } sched_state_t;
endpackage

// File: rtl/gamma_page_scheduler_if.sv
// gamma_page_scheduler_if: config/sync inputs and gamma-lookup control outputs
interface gamma_page_scheduler_if;
    logic [3:0] gammaparams;
    logic       vdata_valid;
    logic       nVSYNC;
    logic [2:0] gamma_rom_page;
    logic       nbypass;
    logic       busy;
    logic       commit;
    modport master (
        output gammaparams, vdata_valid, nVSYNC,
        input  gamma_rom_page, nbypass, busy, commit
    );
    modport slave (
        input  gammaparams, vdata_valid, nVSYNC,
        output gamma_rom_page, nbypass, busy, commit
    );
endinterface

// File: rtl/gamma_page_scheduler_vsync_edge_detect.sv
// vsync_edge_detect: valid-qualified falling-edge detector on nVSYNC, one-cycle frame_start pulse
module vsync_edge_detect (
    input  logic VCLK,
    input  logic nRST,
    input  logic vdata_valid,
    input  logic nVSYNC,
    output logic frame_start
);
    logic nvsync_q;
    always_ff @(posedge VCLK or negedge nRST)
        if (!nRST)
            nvsync_q <= 1'b1;
        else if (vdata_valid)
            nvsync_q <= nVSYNC;
    assign frame_start = vdata_valid & nvsync_q & ~nVSYNC;
endmodule

// File: rtl/gamma_page_scheduler.sv
// gamma_page_scheduler: qualifies gamma settings over whole frames and commits them at vsync
module gamma_page_scheduler #(
    parameter int         STABLE_FRAMES = 2,
    parameter logic [3:0] GAMMA_OFF     = gamma_page_scheduler_pkg::GAMMA_OFF,
    parameter logic [3:0] GAMMA_MAX     = gamma_page_scheduler_pkg::GAMMA_MAX
) (
    input logic                   VCLK,
    input logic                   nRST,
    gamma_page_scheduler_if.slave bus
);
    import gamma_page_scheduler_pkg::*;
    sched_state_t state_q, state_d;
    logic [3:0] eff_code, act_q, act_d, cand_q, cand_d, cnt_q, cnt_d, act_m1;
    logic commit_d, frame_start;
    vsync_edge_detect u_vsync (
        .VCLK        (VCLK),
        .nRST        (nRST),
        .vdata_valid (bus.vdata_valid),
        .nVSYNC      (bus.nVSYNC),
        .frame_start (frame_start)
    );
    assign eff_code = (bus.gammaparams > GAMMA_MAX) ? GAMMA_OFF : bus.gammaparams;
    assign act_m1   = act_q - 4'd1;
    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_d = 1'b0;
        case (state_q)
            IDLE: if (eff_code != act_q) begin
                cand_d  = eff_code;
                cnt_d   = '0;
                state_d = QUAL;
            end
            QUAL: if (eff_code == act_q)
                state_d = IDLE;
            else if (eff_code != cand_q) begin
                cand_d = eff_code;
                cnt_d  = '0;
            end else if (frame_start && cnt_q == 4'(STABLE_FRAMES - 1)) begin
                act_d    = cand_q;
                commit_d = 1'b1;
                state_d  = HOLD;
            end else if (frame_start)
                cnt_d = cnt_q + 4'd1;
            HOLD: if (frame_start)
                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge VCLK or negedge nRST)
        if (!nRST) begin
            state_q            <= IDLE;
            act_q              <= GAMMA_OFF;
            cand_q             <= GAMMA_OFF;
            cnt_q              <= '0;
            bus.commit         <= 1'b0;
            bus.busy           <= 1'b0;
            bus.gamma_rom_page <= '0;
            bus.nbypass        <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            bus.commit <= commit_d;
            bus.busy   <= (state_d != IDLE);
            // act_q only moves on commit, so the translation follows one cycle behind it
            if (bus.commit) begin
                bus.gamma_rom_page <= (act_q < GAMMA_OFF) ? act_q[2:0] : act_m1[2:0];
                bus.nbypass        <= (act_q != GAMMA_OFF);
            end
        end
endmodule

// File: tb/tb_gamma_page_scheduler.sv
// tb_gamma_page_scheduler: randomized video timing checked against a frame-level reference model
module tb_gamma_page_scheduler;
    localparam int STABLE = 2;
    localparam int VLEN   = 40;
    logic VCLK = 1'b0;
    logic nRST = 1'b0;
    always #5 VCLK = ~VCLK;
    gamma_page_scheduler_if bus ();
    gamma_page_scheduler #(.STABLE_FRAMES(STABLE)) dut (
        .VCLK (VCLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );
    int n_cmp = 0, n_bad = 0;
    int m_act, m_cand, m_seen, e_page, commits = 0, vpos = 10;
    bit m_pend, m_hold, m_samp, m_commit, e_nbyp, fs_next;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int page_of(int c);
        return c < 5 ? c : c - 1;
    endfunction
    task automatic model_reset();
        m_act = 5; m_cand = 5; m_seen = 0;
        m_pend = 0; m_hold = 0; m_samp = 1; m_commit = 0;
        e_page = 0; e_nbyp = 0;
    endtask
    task automatic model_step();
        int eff;
        bit fs;
        eff = bus.gammaparams > 8 ? 5 : int'(bus.gammaparams);
        fs = bus.vdata_valid && m_samp && !bus.nVSYNC;
        if (bus.vdata_valid) m_samp = bus.nVSYNC;
        if (m_commit) begin
            e_page = page_of(m_act);
            e_nbyp = (m_act != 5);
        end
        m_commit = 0;
        if (m_hold) m_hold = !fs;
        else if (!m_pend) begin
            if (eff != m_act) begin m_pend = 1; m_cand = eff; m_seen = 0; end
        end else if (eff == m_act) m_pend = 0;
        else if (eff != m_cand) begin m_cand = eff; m_seen = 0; end
        else if (fs) begin
            m_seen++;
            if (m_seen == STABLE) begin
                m_act = m_cand; m_pend = 0; m_hold = 1; m_commit = 1; commits++;
            end
        end
    endtask
    task automatic cycle();
        bit v;
        @(posedge VCLK);
        if (!nRST) model_reset(); else model_step();
        #1;
        check("commit", bus.commit, m_commit);
        check("busy", bus.busy, m_pend || m_hold);
        check("page", bus.gamma_rom_page, e_page);
        check("nbypass", bus.nbypass, e_nbyp);
        v = ($urandom_range(0, 2) != 0);
        bus.vdata_valid = v;
        if (v) begin
            bus.nVSYNC = (vpos >= 3);
            vpos = (vpos + 1) % VLEN;
        end else
            bus.nVSYNC = 1'($urandom_range(0, 1));
        fs_next = v && m_samp && !bus.nVSYNC;
    endtask
    task automatic wait_commit();
        int target = commits + 1;
        for (int i = 0; i < 2000 && commits < target; i++) cycle();
        if (commits < target) check("commit_timeout", commits, target);
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 2000 && (m_pend || m_hold); i++) cycle();
        if (m_pend || m_hold) check("idle_timeout", m_pend || m_hold, 0);
    endtask
    task automatic wait_fs_next();
        for (int i = 0; i < 2000 && !fs_next; i++) cycle();
        if (!fs_next) check("fs_timeout", fs_next, 1);
    endtask
    initial begin
        model_reset();
        bus.gammaparams = 4'd5;
        bus.vdata_valid = 1'b0;
        bus.nVSYNC = 1'b1;
        repeat (3) cycle();
        #2 nRST = 1'b1;
        repeat (300) cycle();
        bus.gammaparams = 4'd2;
        wait_commit();
        repeat (2) cycle();
        check("page_code2", bus.gamma_rom_page, 2);
        check("nbypass_code2", bus.nbypass, 1);
        wait_idle();
        bus.gammaparams = 4'd6;
        cycle();
        wait_fs_next();
        bus.gammaparams = 4'd7;
        cycle();
        check("no_commit_on_toggle", bus.commit, 0);
        wait_commit();
        repeat (2) cycle();
        check("page_code7", bus.gamma_rom_page, 6);
        check("nbypass_code7", bus.nbypass, 1);
        wait_idle();
        bus.gammaparams = 4'd3;
        cycle();
        check("busy_request", bus.busy, 1);
        bus.gammaparams = 4'd7;
        cycle();
        check("busy_withdrawn", bus.busy, 0);
        repeat (200) cycle();
        bus.gammaparams = 4'd12;
        wait_commit();
        repeat (2) cycle();
        check("nbypass_illegal", bus.nbypass, 0);
        wait_idle();
        bus.gammaparams = 4'd8;
        wait_commit();
        cycle();
        #2 nRST = 1'b0;
        #1;
        check("rst_page", bus.gamma_rom_page, 0);
        check("rst_nbypass", bus.nbypass, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_commit", bus.commit, 0);
        model_reset();
        repeat (2) cycle();
        #2 nRST = 1'b1;
        wait_commit();
        repeat (2) cycle();
        check("page_code8", bus.gamma_rom_page, 7);
        check("nbypass_code8", bus.nbypass, 1);
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) == 0) bus.gammaparams = 4'($urandom_range(0, 15));
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
